jpeg_fifo_wr_arb: RTL and testbench
===================================

Name: jpeg_fifo_wr_arb

Overview:
Write-side sequencer for the 512x8 single-clock JPEG byte FIFO. It shares the FIFO write port between the header byte source and the entropy-coder byte source, one frame at a time. It clears the FIFO at frame start, inserts the 0x00 stuff byte after every 0xFF in scan data, and appends the EOI marker (0xFF 0xD9). The FIFO read side (ESP32 drain) is not part of this block.

Parameters:
DEPTH, 512, FIFO depth in bytes
CNT_WIDTH, 10, width of the FIFO occupancy count

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  frame-start pulse; honoured only in IDLE
abort  in  1  synchronous frame abort; wins over start
hdr_valid  in  1  header byte valid
hdr_data  in  8  header byte
hdr_last  in  1  final header byte
hdr_ready  out  1  header byte accepted when hdr_valid & hdr_ready
ent_valid  in  1  entropy byte valid
ent_data  in  8  entropy byte (unstuffed)
ent_last  in  1  final entropy byte of the frame
ent_ready  out  1  entropy byte accepted when ent_valid & ent_ready
fifo_cnt  in  CNT_WIDTH  FIFO occupancy
fifo_wr  out  1  registered FIFO write strobe
fifo_wdata  out  8  registered FIFO write data
fifo_clear  out  1  registered FIFO clear pulse
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse after EOI is written

Behaviour:
- Reset: state=IDLE; fifo_wr=0, fifo_wdata=0x00, fifo_clear=0, frame_done=0, hdr_ready=0, ent_ready=0, last_pend=0.
- space_ok = (fifo_cnt + fifo_wr) < DEPTH. Compute at CNT_WIDTH+1 bits. This is conservative and ignores concurrent reads.
- hdr_ready and ent_ready are combinational from state and space_ok only. They never depend on valid.
- Latency: a byte accepted or generated in cycle t appears as fifo_wr=1 with fifo_wdata in cycle t+1. fifo_wr is 0 in any cycle where nothing is accepted or generated.
- States:
  - IDLE: start -> CLR.
  - CLR: fifo_clear=1 for exactly one cycle, fifo_wr=0 -> HDR.
  - HDR: hdr_ready=space_ok. An accepted byte is written unmodified. An accept with hdr_last -> SCAN.
  - SCAN: ent_ready=space_ok. An accepted byte is written.
    - Byte is 0xFF -> STUFF; last_pend<=ent_last.
    - Byte is not 0xFF and ent_last=1 -> EOI0.
  - STUFF: ent_ready=0. When space_ok, write 0x00, then go to EOI0 if last_pend, otherwise SCAN.
  - EOI0: when space_ok, write 0xFF -> EOI1.
  - EOI1: when space_ok, write 0xD9 -> DONE.
  - DONE: frame_done=1 for one cycle -> IDLE.
- The ready output of the non-active source is always 0. Entropy bytes presented during HDR are held off, not dropped.
- abort in any state other than IDLE:
  - next state is IDLE; fifo_clear=1 for one cycle; fifo_wr=0 in that cycle; last_pend cleared.
  - Any byte presented in the abort cycle is not accepted (readies forced to 0).
- abort in IDLE is ignored. start outside IDLE is ignored.
- Full FIFO: while space_ok=0 the block stalls in its current state with no write and no loss. It resumes on the first cycle where space_ok=1.
- Reset mid-frame: immediate return to the reset values. The FIFO must be reset by the same reset.

Optional Feature:
JE_WR_ARB_BYTECNT_EN
- Defined: adds output frame_bytes [15:0].
  - Cleared in CLR.
  - Incremented on every fifo_wr of the frame, including stuff and EOI bytes.
  - Saturates at 0xFFFF.
  - Holds its value after DONE until the next CLR.
- Undefined: no frame_bytes port and no counter logic. All other behaviour is identical.

Decomposition:
- Shared package jpeg_pkg holds:
  - the state encoding typedef (8 states, 3 bits);
  - marker constants MARKER_FF=8'hFF, STUFF_BYTE=8'h00, EOI_LO=8'hD9;
  - the FIFO DEPTH and CNT_WIDTH defaults.
- No sub-module is needed. If split, only the optional counter is a natural sub-module: jpeg_sat_cnt16.

Test Plan:
- Basic frame:
  - Stimulus: start; header 0xFF,0xD8 (last on 2nd); entropy 0x12,0x34 (last on 2nd).
  - Required: fifo_clear one cycle after start; FIFO writes FF D8 12 34 FF D9; frame_done once; busy low after.
- Stuffing:
  - Stimulus: entropy 0xAB,0xFF,0xCD.
  - Required: writes AB FF 00 CD; ent_ready=0 in the STUFF cycle.
- Last-byte stuffing:
  - Stimulus: entropy 0xFF with ent_last=1.
  - Required: writes FF 00 FF D9, then frame_done.
- Backpressure:
  - Stimulus: fifo_cnt=511 with fifo_wr=0.
  - Required: one accept, then ready=0 while fifo_cnt+fifo_wr>=512; no write lost or duplicated once fifo_cnt drops to 500.
- Abort:
  - Stimulus: abort mid-SCAN with ent_valid=1.
  - Required: that byte is not accepted; fifo_clear pulse; IDLE next cycle; no EOI written; a following start runs a clean frame.
- Reset and priority:
  - Stimulus: async reset asserted mid-HDR.
  - Required: all outputs 0 immediately.
  - Stimulus: start and abort together in IDLE.
  - Required: frame starts (abort ignored in IDLE).

Source files
------------

// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG byte-FIFO write path.
package jpeg_pkg;

  localparam int unsigned FIFO_DEPTH     = 512;
  localparam int unsigned FIFO_CNT_WIDTH = 10;

  localparam logic [7:0] MARKER_FF  = 8'hFF;
  localparam logic [7:0] STUFF_BYTE = 8'h00;
  localparam logic [7:0] EOI_LO     = 8'hD9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_HDR   = 3'd2,
    ST_SCAN  = 3'd3,
    ST_STUFF = 3'd4,
    ST_EOI0  = 3'd5,
    ST_EOI1  = 3'd6,
    ST_DONE  = 3'd7
  } wr_state_e;

endpackage

// File: rtl/jpeg_fifo_wr_arb.sv
// Frame write sequencer for the JPEG byte FIFO: clear, header, stuffed scan data, EOI.
// Optional frame byte counter output enabled by JE_WR_ARB_BYTECNT_EN.
module jpeg_fifo_wr_arb
  import jpeg_pkg::*;
#(
  parameter int unsigned DEPTH     = FIFO_DEPTH,
  parameter int unsigned CNT_WIDTH = FIFO_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 hdr_valid,
  input  logic [7:0]           hdr_data,
  input  logic                 hdr_last,
  output logic                 hdr_ready,
  input  logic                 ent_valid,
  input  logic [7:0]           ent_data,
  input  logic                 ent_last,
  output logic                 ent_ready,
  input  logic [CNT_WIDTH-1:0] fifo_cnt,
  output logic                 fifo_wr,
  output logic [7:0]           fifo_wdata,
  output logic                 fifo_clear,
  output logic                 busy,
  output logic                 frame_done
`ifdef JE_WR_ARB_BYTECNT_EN
  ,
  output logic [15:0]          frame_bytes
`endif
);

  localparam int unsigned OCC_W = CNT_WIDTH + 1;

  wr_state_e         state_q, state_d;
  logic              fifo_wr_q, fifo_wr_d;
  logic [7:0]        fifo_wdata_q, fifo_wdata_d;
  logic              fifo_clear_q, fifo_clear_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q;
  logic              last_pend_q, last_pend_d;
  logic [OCC_W-1:0]  occ;
  logic              space_ok;

  // Occupancy includes the write still in flight this cycle.
  assign occ      = {1'b0, fifo_cnt} + OCC_W'(fifo_wr_q);
  assign space_ok = occ < OCC_W'(DEPTH);

  // Next-state, write generation and source handshakes.
  always_comb begin
    state_d      = state_q;
    fifo_wr_d    = 1'b0;
    fifo_wdata_d = fifo_wdata_q;
    fifo_clear_d = 1'b0;
    frame_done_d = 1'b0;
    last_pend_d  = last_pend_q;
    hdr_ready    = 1'b0;
    ent_ready    = 1'b0;

    if (abort && (state_q != ST_IDLE)) begin
      state_d      = ST_IDLE;
      fifo_clear_d = 1'b1;
      last_pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d      = ST_CLR;
            fifo_clear_d = 1'b1;
          end
        end
        ST_CLR: state_d = ST_HDR;
        ST_HDR: begin
          hdr_ready = space_ok;
          if (hdr_valid && space_ok) begin
            fifo_wr_d    = 1'b1;
            fifo_wdata_d = hdr_data;
            if (hdr_last) state_d = ST_SCAN;
          end
        end
        ST_SCAN: begin
          ent_ready = space_ok;
          if (ent_valid && space_ok) begin
            fifo_wr_d    = 1'b1;
            fifo_wdata_d = ent_data;
            if (ent_data == MARKER_FF) begin
              state_d     = ST_STUFF;
              last_pend_d = ent_last;
            end else if (ent_last) begin
              state_d = ST_EOI0;
            end
          end
        end
        ST_STUFF: begin
          if (space_ok) begin
            fifo_wr_d    = 1'b1;
            fifo_wdata_d = STUFF_BYTE;
            state_d      = last_pend_q ? ST_EOI0 : ST_SCAN;
            last_pend_d  = 1'b0;
          end
        end
        ST_EOI0: begin
          if (space_ok) begin
            fifo_wr_d    = 1'b1;
            fifo_wdata_d = MARKER_FF;
            state_d      = ST_EOI1;
          end
        end
        ST_EOI1: begin
          if (space_ok) begin
            fifo_wr_d    = 1'b1;
            fifo_wdata_d = EOI_LO;
            frame_done_d = 1'b1;
            state_d      = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      fifo_wr_q    <= 1'b0;
      fifo_wdata_q <= 8'h00;
      fifo_clear_q <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      last_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_wdata_q <= fifo_wdata_d;
      fifo_clear_q <= fifo_clear_d;
      frame_done_q <= frame_done_d;
      busy_q       <= (state_d != ST_IDLE);
      last_pend_q  <= last_pend_d;
    end
  end

  assign fifo_wr    = fifo_wr_q;
  assign fifo_wdata = fifo_wdata_q;
  assign fifo_clear = fifo_clear_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

`ifdef JE_WR_ARB_BYTECNT_EN
  logic [15:0] frame_bytes_q;

  // Saturating count of bytes written this frame; held after DONE until next clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_bytes_q <= 16'h0000;
    end else if (state_q == ST_CLR) begin
      frame_bytes_q <= 16'h0000;
    end else if (fifo_wr_q && (frame_bytes_q != 16'hFFFF)) begin
      frame_bytes_q <= frame_bytes_q + 16'd1;
    end
  end

  assign frame_bytes = frame_bytes_q;
`endif

endmodule

// File: tb/tb_jpeg_fifo_wr_arb.sv
// Randomised and directed bench for jpeg_fifo_wr_arb against a byte-stream reference model.
module tb_jpeg_fifo_wr_arb;
  import jpeg_pkg::*;

  localparam int unsigned CW = 10;
  localparam int DEPTH_I = 512;

  logic          clk, reset, start, abort;
  logic          hdr_valid, hdr_last, hdr_ready;
  logic [7:0]    hdr_data;
  logic          ent_valid, ent_last, ent_ready;
  logic [7:0]    ent_data;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_wr, fifo_clear, busy, frame_done;
  logic [7:0]    fifo_wdata;

  jpeg_fifo_wr_arb dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .hdr_valid(hdr_valid), .hdr_data(hdr_data), .hdr_last(hdr_last), .hdr_ready(hdr_ready),
    .ent_valid(ent_valid), .ent_data(ent_data), .ent_last(ent_last), .ent_ready(ent_ready),
    .fifo_cnt(fifo_cnt), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
    .fifo_clear(fifo_clear), .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] hdr_q[$], ent_q[$], cap[$], exp_q[$];
  int cnt = 0, cnt_force = -1, vld_pct = 100, drain_pct = 50, done_cnt = 0;
  bit ent_force = 0, stuff_chk = 0;
  logic s_wr = 1'b0, s_clear = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_sources();
    hdr_valid = (hdr_q.size() > 0) && (int'($urandom_range(99)) < vld_pct);
    hdr_data  = (hdr_q.size() > 0) ? hdr_q[0] : 8'h00;
    hdr_last  = (hdr_q.size() == 1);
    ent_valid = (ent_q.size() > 0) && (ent_force || (int'($urandom_range(99)) < vld_pct));
    ent_data  = (ent_q.size() > 0) ? ent_q[0] : 8'h00;
    ent_last  = (ent_q.size() == 1);
  endtask

  // One clock: drive at negedge, handshake, FIFO occupancy model, sample outputs at next negedge.
  task automatic tick();
    logic acc_h, acc_e;
    int rd;
    drive_sources();
    #1;
    acc_h = hdr_valid & hdr_ready;
    acc_e = ent_valid & ent_ready;
    if (stuff_chk) chk("stuff_ent_ready", 32'(ent_ready), 0);
    if (abort) begin
      chk("abort_hdr_ready", 32'(hdr_ready), 0);
      chk("abort_ent_ready", 32'(ent_ready), 0);
    end
    stuff_chk = acc_e && (ent_data == 8'hFF);
    if (acc_h) void'(hdr_q.pop_front());
    if (acc_e) void'(ent_q.pop_front());
    @(posedge clk);
    #1;
    rd = (cnt > 0 && int'($urandom_range(99)) < drain_pct) ? 1 : 0;
    if (s_clear) cnt = 0;
    else begin
      if (s_wr) chk("no_overflow", 32'(cnt < DEPTH_I), 1);
      cnt = cnt + int'(s_wr) - rd;
    end
    if (cnt_force >= 0) begin
      cnt = cnt_force;
      cnt_force = -1;
    end
    fifo_cnt = CW'(cnt);
    @(negedge clk);
    s_wr = fifo_wr;
    s_clear = fifo_clear;
    if (fifo_clear) cap.delete();
    if (fifo_wr) cap.push_back(fifo_wdata);
    if (frame_done) done_cnt++;
  endtask

  task automatic begin_frame(input string tag, input logic with_abort);
    exp_q.delete();
    foreach (hdr_q[i]) exp_q.push_back(hdr_q[i]);
    foreach (ent_q[i]) begin
      exp_q.push_back(ent_q[i]);
      if (ent_q[i] == 8'hFF) exp_q.push_back(8'h00);
    end
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD9);
    done_cnt = 0;
    start = 1'b1;
    abort = with_abort;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk($sformatf("%s_clear", tag), 32'(fifo_clear), 1);
    chk($sformatf("%s_busy", tag), 32'(busy), 1);
  endtask

  task automatic finish_frame(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    chk($sformatf("%s_done", tag), 32'(done_cnt), 1);
    chk($sformatf("%s_len", tag), 32'(cap.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), (i < cap.size()) ? 32'(cap[i]) : 32'h100, 32'(exp_q[i]));
    tick();
    chk($sformatf("%s_idle_after", tag), 32'(busy), 0);
    chk($sformatf("%s_done_pulse", tag), 32'(frame_done), 0);
    chk($sformatf("%s_done_once", tag), 32'(done_cnt), 1);
  endtask

  initial begin
    int sz, n;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    hdr_valid = 1'b0; hdr_data = 8'h00; hdr_last = 1'b0;
    ent_valid = 1'b0; ent_data = 8'h00; ent_last = 1'b0;
    fifo_cnt = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 32'({fifo_wr, fifo_clear, frame_done, hdr_ready, ent_ready, busy, fifo_wdata}), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_outs", 32'({fifo_wr, fifo_clear, frame_done, hdr_ready, ent_ready, busy}), 0);

    // Basic frame
    vld_pct = 100; drain_pct = 50;
    hdr_q = '{8'hFF, 8'hD8}; ent_q = '{8'h12, 8'h34};
    begin_frame("basic", 1'b0);
    finish_frame("basic", 100);

    // Stuffing mid-scan
    hdr_q = '{8'hFF, 8'hD8}; ent_q = '{8'hAB, 8'hFF, 8'hCD};
    begin_frame("stuff", 1'b0);
    finish_frame("stuff", 100);

    // Stuffing on the last entropy byte
    hdr_q = '{8'hFF}; ent_q = '{8'hFF};
    begin_frame("laststuff", 1'b0);
    finish_frame("laststuff", 100);

    // Backpressure at 511 occupancy
    drain_pct = 0;
    hdr_q = '{8'hFF, 8'hD8}; ent_q = '{8'h12, 8'hFF, 8'h34};
    begin_frame("bp", 1'b0);
    cnt_force = 511;
    tick();
    chk("bp_ready_first", 32'(hdr_ready), 1);
    tick();
    chk("bp_one_accept", 32'(hdr_q.size()), 1);
    repeat (3) begin
      chk("bp_stall_ready", 32'({hdr_ready, ent_ready}), 0);
      tick();
    end
    chk("bp_stall_hold", 32'(hdr_q.size()), 1);
    chk("bp_stall_cap", 32'(cap.size()), 1);
    cnt_force = 500;
    finish_frame("bp", 100);

    // Abort mid-scan with a byte on offer
    drain_pct = 50;
    hdr_q = '{8'hFF, 8'hD8};
    ent_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    begin_frame("abt", 1'b0);
    n = 0;
    while (ent_q.size() > 5 && n < 50) begin
      tick();
      n++;
    end
    chk("abt_in_scan", 32'(ent_q.size() <= 5), 1);
    sz = ent_q.size();
    abort = 1'b1; ent_force = 1'b1;
    tick();
    abort = 1'b0; ent_force = 1'b0;
    chk("abt_not_accepted", 32'(ent_q.size()), 32'(sz));
    chk("abt_clear", 32'(fifo_clear), 1);
    chk("abt_idle", 32'(busy), 0);
    chk("abt_no_wr", 32'(fifo_wr), 0);
    repeat (3) tick();
    chk("abt_no_eoi", 32'(cap.size()), 0);
    chk("abt_no_done", 32'(done_cnt), 0);
    hdr_q.delete(); ent_q.delete();
    hdr_q = '{8'hFF, 8'hD8, 8'hFF, 8'hDB}; ent_q = '{8'h55, 8'hFF, 8'hAA};
    begin_frame("abt_clean", 1'b0);
    finish_frame("abt_clean", 100);

    // Async reset mid-header
    hdr_q = '{8'hFF, 8'hD8, 8'hAA, 8'hBB}; ent_q = '{8'h01, 8'h02};
    begin_frame("rst", 1'b0);
    tick();
    tick();
    #2 reset = 1'b1;
    #1 chk("rst_async_outs", 32'({fifo_wr, fifo_clear, frame_done, hdr_ready, ent_ready, busy, fifo_wdata}), 0);
    @(negedge clk);
    reset = 1'b0;
    hdr_q.delete(); ent_q.delete(); cap.delete();
    cnt = 0; fifo_cnt = '0; s_wr = 1'b0; s_clear = 1'b0; stuff_chk = 1'b0; done_cnt = 0;
    tick();
    chk("rst_stays_idle", 32'({busy, fifo_wr}), 0);

    // start and abort together in IDLE: frame still starts
    hdr_q = '{8'hFF, 8'hD8}; ent_q = '{8'h77, 8'h88};
    begin_frame("prio", 1'b1);
    finish_frame("prio", 100);

    // Random frames
    for (int f = 0; f < 5; f++) begin
      int hl, el;
      hl = int'($urandom_range(4, 1));
      el = int'($urandom_range(14, 1));
      for (int i = 0; i < hl; i++) hdr_q.push_back(8'($urandom));
      for (int i = 0; i < el; i++)
        ent_q.push_back(($urandom_range(3) == 0) ? 8'hFF : 8'($urandom));
      vld_pct = int'($urandom_range(100, 40));
      drain_pct = int'($urandom_range(100, 20));
      begin_frame($sformatf("rnd%0d", f), 1'b0);
      finish_frame($sformatf("rnd%0d", f), 400);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
